// File: rtl/idli_sx_pkg.sv
// rtl/idli_sx_pkg.sv - shared ALU/compare types and sequencer state for the slice-serial execute unit
package idli_sx_pkg;

  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_NE, CMP_LT, CMP_GE} cmp_op_t;
  typedef enum logic {SX_IDLE, SX_RUN} sx_state_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    rhs_inv;
    logic    cin;
    cmp_op_t cmp_op;
    logic    cmp_signed;
  } sx_op_t;

  // Signed ordering uses N!=V; unsigned ordering uses the borrow (!C).
  function automatic logic sx_cmp(input cmp_op_t op, input logic sgn,
                                  input logic z, input logic n,
                                  input logic c, input logic v);
    logic r;
    case (op)
      CMP_EQ:  r = z;
      CMP_NE:  r = !z;
      CMP_LT:  r = sgn ? (n != v) : !c;
      default: r = sgn ? (n == v) : c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idli_sx_slice_alu.sv
// rtl/idli_sx_slice_alu.sv - combinational SLICE_W-bit ALU slice with carry and sign-carry outputs
module idli_sx_slice_alu_m
  import idli_sx_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  alu_op_t              op,
  input  logic [SLICE_W-1:0]   lhs,
  input  logic [SLICE_W-1:0]   rhs,
  input  logic                 cin,
  output logic [SLICE_W-1:0]   out,
  output logic                 cout,
  output logic                 sign_cin
);

  logic [SLICE_W:0] sum;

  always_comb begin
    sum      = {1'b0, lhs} + {1'b0, rhs} + {{SLICE_W{1'b0}}, cin};
    out      = sum[SLICE_W-1:0];
    cout     = 1'b0;
    sign_cin = 1'b0;
    case (op)
      ALU_ADD: begin
        cout     = sum[SLICE_W];
        // carry into the sign bit recovered from the sum bit
        sign_cin = lhs[SLICE_W-1] ^ rhs[SLICE_W-1] ^ sum[SLICE_W-1];
      end
      ALU_AND: out = lhs & rhs;
      ALU_OR:  out = lhs | rhs;
      default: out = lhs ^ rhs;
    endcase
  end

endmodule

// File: rtl/idli_sx_m.sv
// rtl/idli_sx_m.sv - slice-serial execution sequencer: FSM, slice counter, carry/Z chaining, flags and compare
module idli_sx_m
  import idli_sx_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int SLICE_W = 4,
  localparam int NSLICE  = DATA_W / SLICE_W,
  localparam int CTR_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               i_sx_gck,
  input  logic               i_sx_rst,
  input  logic               i_sx_op_vld,
  output logic               o_sx_op_acp,
  input  alu_op_t            i_sx_alu_op,
  input  logic               i_sx_rhs_inv,
  input  logic               i_sx_cin,
  input  cmp_op_t            i_sx_cmp_op,
  input  logic               i_sx_cmp_signed,
  input  logic [SLICE_W-1:0] i_sx_lhs,
  input  logic [SLICE_W-1:0] i_sx_rhs,
  input  logic               i_sx_opnd_vld,
  input  logic               i_sx_flush,
  output logic [SLICE_W-1:0] o_sx_out,
  output logic               o_sx_out_vld,
  output logic [CTR_W-1:0]   o_sx_ctr,
  output logic               o_sx_busy,
  output logic               o_sx_done,
  output logic               o_sx_cmp
);

  sx_state_t          state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               carry_q, carry_d;
  logic               z_acc_q, z_acc_d;
  sx_op_t             op_q, op_d;

  logic [SLICE_W-1:0] alu_out;
  logic               cout, sign_cin, cin_eff;
  logic               run, slice_go, last, z_flag, accept;

  assign run      = (state_q == SX_RUN);
  assign slice_go = run && i_sx_opnd_vld;
  assign last     = slice_go && (ctr_q == CTR_W'(NSLICE - 1));
  assign cin_eff  = (ctr_q == '0) ? op_q.cin : carry_q;
  assign z_flag   = z_acc_q && (alu_out == '0);

  idli_sx_slice_alu_m #(.SLICE_W(SLICE_W)) u_alu (
    .op       (op_q.alu_op),
    .lhs      (i_sx_lhs),
    .rhs      (i_sx_rhs ^ {SLICE_W{op_q.rhs_inv}}),
    .cin      (cin_eff),
    .out      (alu_out),
    .cout     (cout),
    .sign_cin (sign_cin)
  );

  // Accepting on the last slice gives back-to-back issue with no bubble.
  assign o_sx_op_acp  = !i_sx_flush && (!run || last);
  assign accept       = i_sx_op_vld && o_sx_op_acp;
  assign o_sx_out     = slice_go ? alu_out : '0;
  assign o_sx_out_vld = slice_go;
  assign o_sx_ctr     = ctr_q;
  assign o_sx_busy    = run;
  assign o_sx_done    = last && !i_sx_flush;
  assign o_sx_cmp     = o_sx_done && sx_cmp(op_q.cmp_op, op_q.cmp_signed, z_flag,
                                            alu_out[SLICE_W-1], cout, sign_cin ^ cout);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    carry_d = carry_q;
    z_acc_d = z_acc_q;
    op_d    = op_q;
    if (i_sx_flush) begin
      state_d = SX_IDLE;
      ctr_d   = '0;
      z_acc_d = 1'b1;
    end else if (accept) begin
      state_d         = SX_RUN;
      ctr_d           = '0;
      z_acc_d         = 1'b1;
      op_d.alu_op     = i_sx_alu_op;
      op_d.rhs_inv    = i_sx_rhs_inv;
      op_d.cin        = i_sx_cin;
      op_d.cmp_op     = i_sx_cmp_op;
      op_d.cmp_signed = i_sx_cmp_signed;
    end else if (last) begin
      state_d = SX_IDLE;
      ctr_d   = '0;
      z_acc_d = 1'b1;
    end else if (slice_go) begin
      ctr_d   = ctr_q + CTR_W'(1);
      carry_d = cout;
      z_acc_d = z_flag;
    end
  end

  always_ff @(posedge i_sx_gck) begin
    if (i_sx_rst) begin
      state_q <= SX_IDLE;
      ctr_q   <= '0;
      carry_q <= 1'b0;
      z_acc_q <= 1'b1;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      carry_q <= carry_d;
      z_acc_q <= z_acc_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_idli_sx_m.sv
// tb/tb_idli_sx_m.sv - self-checking bench for idli_sx_m (16/4 and 16/16 instances)
module tb_idli_sx_m;
  import idli_sx_pkg::*;

  typedef struct {
    alu_op_t     op;
    logic        inv;
    logic        cin;
    cmp_op_t     cop;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r;
    logic        exp_c;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, op_vld, rhs_inv, cin, cmp_signed, opnd_vld, flush;
  alu_op_t     alu_op;
  cmp_op_t     cmp_op;
  logic [3:0]  lhs, rhs, out;
  logic        acp, out_vld, busy, done, cmp_o;
  logic [1:0]  ctr;

  logic        op_vld_w, opnd_vld_w, acp_w, out_vld_w, busy_w, done_w, cmp_w;
  logic [15:0] lhs_w, rhs_w, out_w;
  logic [0:0]  ctr_w;

  int n_vec = 0;
  int n_err = 0;

  idli_sx_m #(.DATA_W(16), .SLICE_W(4)) dut (
    .i_sx_gck(clk), .i_sx_rst(rst), .i_sx_op_vld(op_vld), .o_sx_op_acp(acp),
    .i_sx_alu_op(alu_op), .i_sx_rhs_inv(rhs_inv), .i_sx_cin(cin),
    .i_sx_cmp_op(cmp_op), .i_sx_cmp_signed(cmp_signed),
    .i_sx_lhs(lhs), .i_sx_rhs(rhs), .i_sx_opnd_vld(opnd_vld), .i_sx_flush(flush),
    .o_sx_out(out), .o_sx_out_vld(out_vld), .o_sx_ctr(ctr), .o_sx_busy(busy),
    .o_sx_done(done), .o_sx_cmp(cmp_o)
  );

  idli_sx_m #(.DATA_W(16), .SLICE_W(16)) dut_w (
    .i_sx_gck(clk), .i_sx_rst(rst), .i_sx_op_vld(op_vld_w), .o_sx_op_acp(acp_w),
    .i_sx_alu_op(alu_op), .i_sx_rhs_inv(rhs_inv), .i_sx_cin(cin),
    .i_sx_cmp_op(cmp_op), .i_sx_cmp_signed(cmp_signed),
    .i_sx_lhs(lhs_w), .i_sx_rhs(rhs_w), .i_sx_opnd_vld(opnd_vld_w), .i_sx_flush(flush),
    .o_sx_out(out_w), .o_sx_out_vld(out_vld_w), .o_sx_ctr(ctr_w), .o_sx_busy(busy_w),
    .o_sx_done(done_w), .o_sx_cmp(cmp_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-word reference: 17-bit arithmetic, overflow from operand/result signs.
  function automatic void model(input vec_t v, output logic [15:0] r, output logic c);
    logic [16:0] s;
    logic [15:0] bb;
    logic z, n, cf, ov;
    bb = v.inv ? ~v.b : v.b;
    case (v.op)
      ALU_ADD: s = {1'b0, v.a} + {1'b0, bb} + {16'd0, v.cin};
      ALU_AND: s = {1'b0, v.a & bb};
      ALU_OR:  s = {1'b0, v.a | bb};
      default: s = {1'b0, v.a ^ bb};
    endcase
    r  = s[15:0];
    z  = (r == 16'd0);
    n  = r[15];
    cf = (v.op == ALU_ADD) ? s[16] : 1'b0;
    ov = (v.op == ALU_ADD) ? ((v.a[15] == bb[15]) && (r[15] != v.a[15])) : 1'b0;
    case (v.cop)
      CMP_EQ:  c = z;
      CMP_NE:  c = !z;
      CMP_LT:  c = v.sgn ? (n != ov) : !cf;
      default: c = v.sgn ? (n == ov) : cf;
    endcase
  endfunction

  task automatic set_op(input vec_t v);
    alu_op = v.op; rhs_inv = v.inv; cin = v.cin; cmp_op = v.cop; cmp_signed = v.sgn;
  endtask

  task automatic drive_slice(input vec_t v, input int k);
    opnd_vld = 1'b1;
    lhs = v.a[4*k +: 4];
    rhs = v.b[4*k +: 4];
  endtask

  task automatic offer(input vec_t v);
    set_op(v); op_vld = 1'b1; opnd_vld = 1'b0;
    #1 chk("acp_idle", acp, 1);
    @(posedge clk); #1;
    op_vld = 1'b0;
  endtask

  task automatic feed(input vec_t v, input int stall_at, input int stall_n, input bit rnd,
                      input bit chain, input vec_t nxt,
                      output logic [15:0] res, output logic cmpv, output int cyc);
    int ns;
    res = '0; cmpv = 1'b0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      ns = (k == stall_at) ? stall_n : 0;
      if (rnd && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) begin
        opnd_vld = 1'b0; lhs = 4'($urandom); rhs = 4'($urandom);
        #1;
        chk("stall_ctr", ctr, k);
        chk("stall_out_vld", out_vld, 0);
        chk("stall_done", done, 0);
        chk("stall_busy", busy, 1);
        cyc++;
        @(posedge clk); #1;
      end
      drive_slice(v, k);
      if (chain && k == 3) begin set_op(nxt); op_vld = 1'b1; end
      #1;
      chk("ctr", ctr, k);
      chk("out_vld", out_vld, 1);
      chk("done", done, (k == 3));
      if (chain && k == 3) chk("acp_on_done", acp, 1);
      res[4*k +: 4] = out;
      if (k == 3) cmpv = cmp_o;
      cyc++;
      @(posedge clk); #1;
      op_vld = 1'b0;
    end
    opnd_vld = 1'b0;
    #1;
    chk("busy_after", busy, chain);
    chk("ctr_after", ctr, 0);
  endtask

  task automatic run_op(input vec_t v, input int stall_at, input int stall_n, input bit rnd,
                        output logic [15:0] res, output logic cmpv, output int cyc);
    offer(v);
    feed(v, stall_at, stall_n, rnd, 1'b0, v, res, cmpv, cyc);
  endtask

  task automatic run_w(input logic [15:0] a, input logic [15:0] b, input cmp_op_t cop,
                       input logic [15:0] er, input logic ec);
    alu_op = ALU_ADD; rhs_inv = 1'b0; cin = 1'b0; cmp_op = cop; cmp_signed = 1'b0;
    op_vld_w = 1'b1;
    #1 chk("w_acp", acp_w, 1);
    @(posedge clk); #1;
    op_vld_w = 1'b0; opnd_vld_w = 1'b1; lhs_w = a; rhs_w = b;
    #1;
    chk("w_out", out_w, er);
    chk("w_done", done_w, 1);
    chk("w_ctr", ctr_w, 0);
    chk("w_cmp", cmp_w, ec);
    @(posedge clk); #1;
    opnd_vld_w = 1'b0;
    #1 chk("w_idle", busy_w, 0);
  endtask

  vec_t        tbl[10];
  vec_t        v, v2;
  logic [15:0] res, er;
  logic        cv, ec;
  int          cyc;

  initial begin
    rst = 1'b1; op_vld = 1'b0; alu_op = ALU_ADD; rhs_inv = 1'b0; cin = 1'b0;
    cmp_op = CMP_EQ; cmp_signed = 1'b0; lhs = '0; rhs = '0; opnd_vld = 1'b0; flush = 1'b0;
    op_vld_w = 1'b0; opnd_vld_w = 1'b0; lhs_w = '0; rhs_w = '0;

    tbl[0] = '{ALU_ADD, 1'b0, 1'b0, CMP_EQ, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0};
    tbl[1] = '{ALU_ADD, 1'b1, 1'b1, CMP_LT, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1};
    tbl[2] = '{ALU_ADD, 1'b1, 1'b1, CMP_LT, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1};
    tbl[3] = '{ALU_ADD, 1'b1, 1'b1, CMP_LT, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    tbl[4] = '{ALU_ADD, 1'b1, 1'b1, CMP_LT, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0};
    tbl[5] = '{ALU_XOR, 1'b0, 1'b0, CMP_EQ, 1'b0, 16'h00F0, 16'h00F0, 16'h0000, 1'b1};
    tbl[6] = '{ALU_AND, 1'b0, 1'b0, CMP_NE, 1'b0, 16'hFF0F, 16'h0FF0, 16'h0F00, 1'b1};
    tbl[7] = '{ALU_OR,  1'b0, 1'b0, CMP_EQ, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    tbl[8] = '{ALU_ADD, 1'b1, 1'b1, CMP_GE, 1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};
    tbl[9] = '{ALU_ADD, 1'b0, 1'b0, CMP_GE, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; lhs = 4'hA; rhs = 4'h5; lhs_w = 16'h1234; rhs_w = 16'h4321;
    #1;
    chk("rst_acp", acp, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmp", cmp_o, 0);
    chk("rst_out", out, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_ctr", ctr, 0);
    chk("rst_w_acp", acp_w, 1);
    chk("rst_w_out", out_w, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], -1, 0, 1'b0, res, cv, cyc);
      chk($sformatf("tbl%0d_res", i), res, tbl[i].exp_r);
      chk($sformatf("tbl%0d_cmp", i), cv, tbl[i].exp_c);
      chk($sformatf("tbl%0d_cyc", i), cyc, 4);
    end

    // stall of three cycles after slice 0 must hold carry across the gap
    v = '{ALU_ADD, 1'b0, 1'b0, CMP_EQ, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
    run_op(v, 1, 3, 1'b0, res, cv, cyc);
    chk("stall_res", res, 16'h0100);
    chk("stall_cmp", cv, 0);
    chk("stall_cyc", cyc, 7);

    // back-to-back: nonzero op then zero-result op must see a fresh Z
    v  = '{ALU_ADD, 1'b0, 1'b0, CMP_EQ, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0};
    v2 = '{ALU_XOR, 1'b0, 1'b0, CMP_EQ, 1'b0, 16'h5555, 16'h5555, 16'h0000, 1'b1};
    offer(v);
    feed(v, -1, 0, 1'b0, 1'b1, v2, res, cv, cyc);
    chk("b2b_a_res", res, 16'h1234);
    chk("b2b_a_cmp", cv, 0);
    feed(v2, -1, 0, 1'b0, 1'b0, v2, res, cv, cyc);
    chk("b2b_b_res", res, 16'h0000);
    chk("b2b_b_cmp", cv, 1);
    chk("b2b_b_cyc", cyc, 4);

    // flush at ctr=2 and then reset at ctr=2; both abort and allow re-issue
    for (int mode = 0; mode < 2; mode++) begin
      offer(tbl[0]);
      for (int k = 0; k < 2; k++) begin drive_slice(tbl[0], k); @(posedge clk); #1; end
      drive_slice(tbl[0], 2); op_vld = 1'b1; set_op(tbl[0]);
      if (mode == 0) flush = 1'b1; else rst = 1'b1;
      #1;
      chk("kill_ctr", ctr, 2);
      if (mode == 0) begin
        chk("flush_acp", acp, 0);
        chk("flush_done", done, 0);
        chk("flush_cmp", cmp_o, 0);
      end
      @(posedge clk); #1;
      flush = 1'b0; rst = 1'b0; op_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
        drive_slice(tbl[0], k);
        #1;
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        chk("kill_ctr0", ctr, 0);
        @(posedge clk); #1;
      end
      opnd_vld = 1'b0;
      run_op(tbl[0], -1, 0, 1'b0, res, cv, cyc);
      chk("reissue_res", res, 16'h2201);
      chk("reissue_cyc", cyc, 4);
    end

    // flush while idle drops the offered op
    set_op(tbl[0]); op_vld = 1'b1; flush = 1'b1;
    #1 chk("idle_flush_acp", acp, 0);
    @(posedge clk); #1;
    op_vld = 1'b0; flush = 1'b0;
    #1 chk("idle_flush_busy", busy, 0);

    for (int i = 0; i < 60; i++) begin
      v.op  = alu_op_t'($urandom_range(0, 3));
      v.inv = 1'($urandom);
      v.cin = 1'($urandom);
      v.cop = cmp_op_t'($urandom_range(0, 3));
      v.sgn = 1'($urandom);
      v.a   = 16'($urandom);
      v.b   = (i % 5 == 0) ? (v.inv ? ~v.a : v.a) : 16'($urandom);
      model(v, er, ec);
      run_op(v, -1, 0, 1'b1, res, cv, cyc);
      chk($sformatf("rnd%0d_res", i), res, er);
      chk($sformatf("rnd%0d_cmp", i), cv, ec);
    end

    run_w(16'hFFFF, 16'h0001, CMP_EQ, 16'h0000, 1'b1);
    run_w(16'hFFFF, 16'h0001, CMP_GE, 16'h0000, 1'b1);
    run_w(16'h1234, 16'h0FCD, CMP_EQ, 16'h2201, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
